sample_feeder: RTL and testbench
================================

Name: sample_feeder

Overview:
- Training-set sequencer directly upstream of the perceptron neuron.
- Holds up to DEPTH labelled samples (x1, x2, t) in an internal register file, loaded over a simple write port.
- On go, issues the neuron's start pulse, then streams the samples epoch after epoch with EOI/EOF framing.
- Repeats epochs until the neuron reports learned or an epoch passes with no weight update, or stops after MAX_EPOCHS.

Parameters:
- DEPTH, 8: sample storage entries.
- HOLD, 3: cycles each sample is held on x1/x2/tin (≥1).
- CHECK_DELAY, 2: cycles waited after the EOF cycle before sampling learned (≥1).
- MAX_EPOCHS, 15: epoch limit before declaring failure (≥1).

Ports:
- clk  in  1  Single system clock, rising edge.
- rst  in  1  Asynchronous, active-low reset.
- wr_en  in  1  Sample write strobe.
- wr_addr  in  clog2(DEPTH)  Write address.
- wr_x1, wr_x2  in  7 signed  Sample features.
- wr_t  in  2 signed  Sample target (+1/−1).
- n_samples  in  clog2(DEPTH+1)  Samples per epoch; latched at go.
- go  in  1  Begin training, single-cycle.
- learned  in  1  From neuron.
- updating  in  1  From neuron; weights changing this cycle.
- start  out  1  One-cycle pulse to neuron.
- x1, x2  out  7 signed  Current sample to neuron.
- tin  out  2 signed  Current target to neuron.
- EOI  out  1  Last cycle of the current sample.
- EOF  out  1  Coincides with EOI on the last sample of an epoch.
- busy  out  1  High in START/FEED/CHECK.
- done  out  1  Training converged.
- fail  out  1  Epoch limit reached or bad n_samples.
- epochs  out  clog2(MAX_EPOCHS+1)  Epochs completed.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal address, hold, epoch and dirty registers cleared. Storage contents are not reset. Reset mid-operation aborts immediately to the same state.
- Writes: accepted only when busy=0 and take effect on the next edge; wr_en while busy=1 is ignored.
- IDLE/DONE/FAIL on go:
  - If n_samples==0 or n_samples>DEPTH: go to FAIL, epochs=0.
  - Otherwise: latch n_samples, clear epochs/addr/dirty, clear done/fail, go to START.
- START: start=1 for exactly this cycle, then FEED. No further start pulses until the next go.
- FEED:
  - x1/x2/tin are registered from storage[addr] and valid from the first FEED cycle of each sample. They are held for HOLD cycles, so sample k first appears HOLD·k+1 cycles after the start cycle.
  - On the last hold cycle EOI=1. If addr==n_samples−1, EOF=1 in the same cycle and the next state is CHECK; otherwise addr increments.
- dirty flag: set by any cycle with updating=1 in START, FEED or CHECK.
- CHECK: waits CHECK_DELAY cycles, then increments epochs and decides, in priority order:
  - learned=1 or dirty=0: go to DONE.
  - epochs reached MAX_EPOCHS: go to FAIL.
  - Otherwise clear dirty, set addr=0 and return to FEED.
- Outputs outside FEED:
  - x1/x2/tin hold their last values.
  - EOI/EOF are 0 outside FEED.
- DONE/FAIL: done or fail stays high (level) until the next accepted go or reset; busy=0.
- Simultaneous go and wr_en in IDLE: both take effect. The write lands in storage before the first FEED read.
- go while busy: ignored.

Optional Feature:
- FEEDER_ALTERNATE_EN
  - Defined: epochs with an odd index (second, fourth, …) traverse addresses n_samples−1 down to 0. EOF then marks address 0 on those epochs.
  - Undefined: every epoch runs 0 to n_samples−1.

Test Plan:
- Reset during FEED (rst low for 1 cycle) -> start, EOI, EOF, busy, done, fail and epochs all 0 asynchronously; state IDLE; a following go restarts from addr 0.
- Load 4 samples {(3,2,+1),(−1,−4,−1),(5,−2,+1),(−6,1,−1)}, n_samples=4, HOLD=3, learned=0, updating pulsed once per epoch -> start once; 4 EOI pulses spaced 3 cycles apart per epoch; EOF on the 4th; after 15 epochs fail=1, epochs=15.
- Same load; updating never asserted -> done=1 after the first CHECK, epochs=1, exactly 4 EOI and 1 EOF.
- updating pulsed in epochs 1–2, learned=1 raised during CHECK of epoch 3 -> done=1, epochs=3.
- go with n_samples=0, and separately with 9 (DEPTH=8) -> fail=1 the next cycle, epochs=0, no start pulse.
- wr_en to addr 0 while busy -> storage unchanged; the next epoch still presents the original x1=3.

Source files
------------

// File: rtl/sample_feeder.sv
// sample_feeder: training-set sequencer sitting in front of the perceptron neuron.
// Stores up to DEPTH labelled samples, then on go pulses start and streams the
// samples epoch after epoch with EOI/EOF framing until the neuron converges,
// an epoch passes with no weight update, or MAX_EPOCHS epochs have run.
//
// Optional feature: define FEEDER_ALTERNATE_EN to make odd-indexed epochs walk
// the samples from n_samples-1 down to 0 (EOF then marks address 0).

module sample_feeder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD        = 3,
    parameter int unsigned CHECK_DELAY = 2,
    parameter int unsigned MAX_EPOCHS  = 15,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NW = $clog2(DEPTH + 1),
    localparam int unsigned EW = $clog2(MAX_EPOCHS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [6:0]    wr_x1,
    input  logic signed [6:0]    wr_x2,
    input  logic signed [1:0]    wr_t,
    input  logic [NW-1:0]        n_samples,
    input  logic                 go,
    input  logic                 learned,
    input  logic                 updating,
    output logic                 start,
    output logic signed [6:0]    x1,
    output logic signed [6:0]    x2,
    output logic signed [1:0]    tin,
    output logic                 EOI,
    output logic                 EOF,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [EW-1:0]        epochs
);

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned CW = (CHECK_DELAY > 1) ? $clog2(CHECK_DELAY) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StFeed  = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;
    localparam logic [2:0] StFail  = 3'd5;

    localparam logic [HW-1:0] HoldLast  = HW'(HOLD - 1);
    localparam logic [CW-1:0] CheckLast = CW'(CHECK_DELAY - 1);
    localparam logic [EW-1:0] EpochLast = EW'(MAX_EPOCHS - 1);

    // Sample storage (not reset)
    logic signed [6:0] mem_x1_q [DEPTH];
    logic signed [6:0] mem_x2_q [DEPTH];
    logic signed [1:0] mem_t_q  [DEPTH];

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     chk_q, chk_d;
    logic [EW-1:0]     epochs_q, epochs_d;
    logic              dirty_q, dirty_d;
    logic [NW-1:0]     n_q, n_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic signed [6:0] x1_q, x2_q;
    logic signed [1:0] tin_q;

    logic              busy_w;
    logic              wr_fire;
    logic              load;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     n_last;
    logic [AW-1:0]     last_addr;
    logic [AW-1:0]     step_addr;
    logic [AW-1:0]     next_first;
    logic              rev_cur;
    logic              rev_next;
    logic              hold_end;

    // Direction of the current and of the following epoch
    always_comb begin
`ifdef FEEDER_ALTERNATE_EN
        // epochs_q equals the 0-based index of the epoch being fed
        rev_cur  = epochs_q[0];
        rev_next = ~epochs_q[0];
`else
        rev_cur  = 1'b0;
        rev_next = 1'b0;
`endif
        n_last     = AW'(n_q - NW'(1));
        last_addr  = rev_cur ? '0 : n_last;
        step_addr  = rev_cur ? (addr_q - AW'(1)) : (addr_q + AW'(1));
        next_first = rev_next ? n_last : '0;
    end

    assign busy_w   = (state_q == StStart) || (state_q == StFeed) || (state_q == StCheck);
    assign hold_end = (state_q == StFeed) && (hold_q == HoldLast);

    // Writes are only accepted while idle; out-of-range addresses are dropped
    assign wr_fire = wr_en && !busy_w && (32'(wr_addr) < DEPTH);

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_x1_q[wr_addr] <= wr_x1;
            mem_x2_q[wr_addr] <= wr_x2;
            mem_t_q[wr_addr]  <= wr_t;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        hold_d   = hold_q;
        chk_d    = chk_q;
        epochs_d = epochs_q;
        dirty_d  = dirty_q;
        n_d      = n_q;
        done_d   = done_q;
        fail_d   = fail_q;
        load     = 1'b0;
        rd_addr  = addr_q;

        if (busy_w && updating) begin
            dirty_d = 1'b1;
        end

        case (state_q)
            StIdle, StDone, StFail: begin
                if (go) begin
                    done_d   = 1'b0;
                    epochs_d = '0;
                    if ((n_samples == '0) || (n_samples > NW'(DEPTH))) begin
                        fail_d  = 1'b1;
                        state_d = StFail;
                    end else begin
                        fail_d  = 1'b0;
                        n_d     = n_samples;
                        addr_d  = '0;
                        dirty_d = 1'b0;
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                // addr_q was cleared at go; first epoch always runs forward
                hold_d  = '0;
                load    = 1'b1;
                rd_addr = addr_q;
                state_d = StFeed;
            end
            StFeed: begin
                if (hold_q == HoldLast) begin
                    hold_d = '0;
                    if (addr_q == last_addr) begin
                        chk_d   = '0;
                        state_d = StCheck;
                    end else begin
                        addr_d  = step_addr;
                        load    = 1'b1;
                        rd_addr = step_addr;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            StCheck: begin
                if (chk_q == CheckLast) begin
                    epochs_d = epochs_q + EW'(1);
                    // An update in this very cycle still counts for the epoch
                    if (learned || !(dirty_q || updating)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (epochs_q == EpochLast) begin
                        fail_d  = 1'b1;
                        state_d = StFail;
                    end else begin
                        dirty_d = 1'b0;
                        hold_d  = '0;
                        addr_d  = next_first;
                        load    = 1'b1;
                        rd_addr = next_first;
                        state_d = StFeed;
                    end
                end else begin
                    chk_d = chk_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            hold_q   <= '0;
            chk_q    <= '0;
            epochs_q <= '0;
            dirty_q  <= 1'b0;
            n_q      <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            hold_q   <= hold_d;
            chk_q    <= chk_d;
            epochs_q <= epochs_d;
            dirty_q  <= dirty_d;
            n_q      <= n_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
        end
    end

    // Sample output registers, reloaded on the first cycle of each sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1_q  <= '0;
            x2_q  <= '0;
            tin_q <= '0;
        end else if (load) begin
            x1_q  <= mem_x1_q[rd_addr];
            x2_q  <= mem_x2_q[rd_addr];
            tin_q <= mem_t_q[rd_addr];
        end
    end

    assign start  = (state_q == StStart);
    assign busy   = busy_w;
    assign EOI    = hold_end;
    assign EOF    = hold_end && (addr_q == last_addr);
    assign done   = done_q;
    assign fail   = fail_q;
    assign epochs = epochs_q;
    assign x1     = x1_q;
    assign x2     = x2_q;
    assign tin    = tin_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder with default parameters
// (DEPTH=8, HOLD=3, CHECK_DELAY=2, MAX_EPOCHS=15).

module tb_sample_feeder;

    localparam int HOLD = 3;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic signed [6:0] wr_x1;
    logic signed [6:0] wr_x2;
    logic signed [1:0] wr_t;
    logic [3:0]        n_samples;
    logic              go;
    logic              learned;
    logic              updating;
    logic              start;
    logic signed [6:0] x1;
    logic signed [6:0] x2;
    logic signed [1:0] tin;
    logic              EOI;
    logic              EOF;
    logic              busy;
    logic              done;
    logic              fail;
    logic [3:0]        epochs;

    int n_cmp = 0;
    int n_bad = 0;

    // monitor counters
    int cyc = 0;
    int start_cnt = 0;
    int eoi_cnt = 0;
    int eof_cnt = 0;
    int gap_err = 0;
    int last_eoi = 0;
    bit have_last = 0;
    bit last_was_eof = 0;

    // updating driver state
    int upd_budget = 0;
    int upd_cnt = 0;
    logic eof_seen;
    logic start_seen;

    int s_start, s_eoi, s_eof, s_gap;

    sample_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_x1     (wr_x1),
        .wr_x2     (wr_x2),
        .wr_t      (wr_t),
        .n_samples (n_samples),
        .go        (go),
        .learned   (learned),
        .updating  (updating),
        .start     (start),
        .x1        (x1),
        .x2        (x2),
        .tin       (tin),
        .EOI       (EOI),
        .EOF       (EOF),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .epochs    (epochs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count framing pulses and flag EOI spacing other than HOLD inside an epoch
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cnt <= start_cnt + 1;
        if (EOF) eof_cnt <= eof_cnt + 1;
        if (EOI) begin
            eoi_cnt <= eoi_cnt + 1;
            if (have_last && !last_was_eof && (cyc - last_eoi) != HOLD) gap_err <= gap_err + 1;
            last_eoi <= cyc;
            have_last <= 1'b1;
            last_was_eof <= EOF;
        end
        if (start || !rst) have_last <= 1'b0;
    end

    // Pulse updating in the cycle after EOF, for at most upd_budget epochs per run
    initial updating = 1'b0;
    always begin
        @(posedge clk);
        eof_seen = EOF;
        start_seen = start;
        #1;
        if (start_seen) upd_cnt = 0;
        if (eof_seen && upd_cnt < upd_budget) begin
            updating = 1'b1;
            upd_cnt++;
        end else begin
            updating = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_sample(input int a, input int v1, input int v2, input int t);
        wr_addr = 3'(a);
        wr_x1 = 7'(v1);
        wr_x2 = 7'(v2);
        wr_t = 2'(t);
        wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_eof(input string tag, input int bound);
        int n = 0;
        tick(1);
        while (!EOF && n < bound) begin
            tick(1);
            n++;
        end
        check(tag, EOF, 1);
    endtask

    task automatic wait_end(input string tag, input int bound);
        int n = 0;
        tick(1);
        while (!(done || fail) && n < bound) begin
            tick(1);
            n++;
        end
        check(tag, done | fail, 1);
    endtask

    task automatic snap();
        s_start = start_cnt;
        s_eoi = eoi_cnt;
        s_eof = eof_cnt;
        s_gap = gap_err;
    endtask

    task automatic pulse_go(input int n);
        n_samples = 4'(n);
        go = 1'b1;
        tick(1);
        go = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_x1 = '0;
        wr_x2 = '0;
        wr_t = '0;
        n_samples = '0;
        go = 1'b0;
        learned = 1'b0;

        // Reset state
        tick(2);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_epochs", epochs, 0);
        check("rst_eoi", EOI, 0);
        check("rst_x1", x1, 0);
        rst = 1'b1;
        tick(1);

        write_sample(0, 3, 2, 1);
        write_sample(1, -1, -4, -1);
        write_sample(2, 5, -2, 1);
        write_sample(3, -6, 1, -1);
        tick(1);

        // A: no updates -> done after one epoch
        upd_budget = 0;
        snap();
        pulse_go(4);
        check("a_start", start, 1);
        check("a_busy", busy, 1);
        tick(1);
        check("a_s0_x1", x1, 3);
        check("a_s0_x2", x2, 2);
        check("a_s0_t", tin, 1);
        check("a_s0_eoi", EOI, 0);
        tick(2);
        check("a_s0_eoi_last", EOI, 1);
        check("a_s0_eof", EOF, 0);
        tick(1);
        check("a_s1_x1", x1, -1);
        check("a_s1_x2", x2, -4);
        check("a_s1_t", tin, -1);
        check("a_s1_eoi", EOI, 0);
        wait_end("a_end", 100);
        check("a_done", done, 1);
        check("a_fail", fail, 0);
        check("a_busy_end", busy, 0);
        check("a_epochs", epochs, 1);
        check("a_eoi_cnt", eoi_cnt - s_eoi, 4);
        check("a_eof_cnt", eof_cnt - s_eof, 1);
        check("a_start_cnt", start_cnt - s_start, 1);
        check("a_eoi_gap", gap_err - s_gap, 0);

        // Bad n_samples = 0
        tick(1);
        snap();
        pulse_go(0);
        check("n0_fail", fail, 1);
        check("n0_done", done, 0);
        check("n0_epochs", epochs, 0);
        check("n0_busy", busy, 0);
        check("n0_start", start, 0);
        tick(2);
        check("n0_start_cnt", start_cnt - s_start, 0);

        // D: updates in epochs 1-2, learned raised during CHECK of epoch 3
        upd_budget = 2;
        tick(1);
        pulse_go(4);
        check("d_fail_clr", fail, 0);
        wait_eof("d_eof1", 50);
        wait_eof("d_eof2", 50);
        wait_eof("d_eof3", 50);
        learned = 1'b1;
        wait_end("d_end", 20);
        learned = 1'b0;
        check("d_done", done, 1);
        check("d_fail", fail, 0);
        check("d_epochs", epochs, 3);

        // Bad n_samples = 9
        tick(1);
        snap();
        pulse_go(9);
        check("n9_fail", fail, 1);
        check("n9_done", done, 0);
        check("n9_epochs", epochs, 0);
        tick(2);
        check("n9_start_cnt", start_cnt - s_start, 0);

        // C: update every epoch -> fail after 15; write while busy is dropped
        upd_budget = 100;
        tick(1);
        snap();
        pulse_go(4);
        check("c_start", start, 1);
        write_sample(0, 50, 50, 1);
        wait_eof("c_eof1", 50);
        tick(3);
        check("c_ep2_x1", x1, 3);
        check("c_ep2_x2", x2, 2);
        wait_end("c_end", 400);
        check("c_fail", fail, 1);
        check("c_done", done, 0);
        check("c_epochs", epochs, 15);
        check("c_busy", busy, 0);
        check("c_eoi_cnt", eoi_cnt - s_eoi, 60);
        check("c_eof_cnt", eof_cnt - s_eof, 15);
        check("c_start_cnt", start_cnt - s_start, 1);
        check("c_eoi_gap", gap_err - s_gap, 0);

        // E: reset during FEED of epoch 2, then restart from address 0
        tick(1);
        pulse_go(4);
        wait_eof("e_eof1", 50);
        tick(3);
        check("e_pre_epochs", epochs, 1);
        check("e_pre_busy", busy, 1);
        tick(1);
        rst = 1'b0;
        #1;
        check("e_rst_start", start, 0);
        check("e_rst_eoi", EOI, 0);
        check("e_rst_eof", EOF, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_done", done, 0);
        check("e_rst_fail", fail, 0);
        check("e_rst_epochs", epochs, 0);
        check("e_rst_x1", x1, 0);
        #2;
        rst = 1'b1;
        tick(1);
        check("e_idle_busy", busy, 0);
        pulse_go(4);
        check("e_start", start, 1);
        tick(1);
        check("e_s0_x1", x1, 3);
        tick(2);
        check("e_s0_eoi", EOI, 1);
        tick(1);
        check("e_s1_x1", x1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
